// File: rtl/comm_uart_pkg.sv
// comm_uart_pkg: shared constants, types and hex helpers for the host side
// of the hex-over-UART mining link.
//   CHAR_LF / CHAR_CR   : line terminators
//   NONCE_DIGITS / TEMP_DIGITS : digit counts that identify a line type
//   hex_encode          : nibble -> uppercase ASCII
//   hex_decode          : ASCII -> {valid, nibble}, accepts either case
package comm_uart_pkg;

    localparam logic [7:0] CHAR_LF           = 8'h0A;
    localparam logic [7:0] CHAR_CR           = 8'h0D;
    localparam int         NONCE_DIGITS      = 8;
    localparam int         TEMP_DIGITS       = 4;
    localparam int         WORK_BITS_DEFAULT = 352;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_NL   = 2'd2
    } tx_state_t;

    typedef enum logic {
        NIB_HI = 1'b0,
        NIB_LO = 1'b1
    } nib_phase_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hex_dec_t;

    // The miner only decodes uppercase, so never emit 'a'-'f'.
    function automatic logic [7:0] hex_encode(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};  // 8'h41 - 10
    endfunction

    function automatic hex_dec_t hex_decode(input logic [7:0] b);
        hex_dec_t r;
        r.valid  = 1'b0;
        r.nibble = 4'h0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r.valid  = 1'b1;
            r.nibble = b[3:0];
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            // low nibble of 'A'/'a' is 1, so +9 lands on 10
            r.valid  = 1'b1;
            r.nibble = b[3:0] + 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/comm_hex_line_decoder.sv
// comm_hex_line_decoder: RX path. Accumulates hex digits from uart_receiver
// and classifies each '\n'-terminated line.
//   clk, reset           : clock, synchronous active-high reset
//   rx_new_byte, rx_byte : byte strobe and data from uart_receiver
//   nonce_valid, nonce   : 8-digit line -> golden nonce (pulse + held value)
//   temp_valid, temp     : 4-digit line -> temperature code (pulse + held value)
//   rx_error             : pulse on any other non-blank line
module comm_hex_line_decoder
    import comm_uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_new_byte,
    input  logic [7:0]  rx_byte,
    output logic        nonce_valid,
    output logic [31:0] nonce,
    output logic        temp_valid,
    output logic [15:0] temp,
    output logic        rx_error
);

    localparam logic [3:0] CNT_MAX   = 4'd9;
    localparam logic [3:0] CNT_NONCE = 4'(NONCE_DIGITS);
    localparam logic [3:0] CNT_TEMP  = 4'(TEMP_DIGITS);

    logic [31:0] acc;
    logic [3:0]  count;
    logic        bad;
    hex_dec_t    dec;

    assign dec = hex_decode(rx_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            count       <= '0;
            bad         <= 1'b0;
            nonce_valid <= 1'b0;
            temp_valid  <= 1'b0;
            rx_error    <= 1'b0;
            nonce       <= '0;
            temp        <= '0;
        end else begin
            nonce_valid <= 1'b0;
            temp_valid  <= 1'b0;
            rx_error    <= 1'b0;
            if (rx_new_byte) begin
                if (dec.valid) begin
                    acc <= {acc[27:0], dec.nibble};
                    // saturating at 9 keeps over-long lines distinguishable from 8
                    if (count != CNT_MAX) count <= count + 4'd1;
                end else if (rx_byte == CHAR_CR) begin
                    // CR of a CRLF pair carries no information
                end else if (rx_byte == CHAR_LF) begin
                    if (!bad && count == CNT_NONCE) begin
                        nonce       <= acc;
                        nonce_valid <= 1'b1;
                    end else if (!bad && count == CNT_TEMP) begin
                        temp       <= acc[15:0];
                        temp_valid <= 1'b1;
                    end else if (bad || count != 4'd0) begin
                        rx_error <= 1'b1;
                    end
                    acc   <= '0;
                    count <= '0;
                    bad   <= 1'b0;
                end else begin
                    bad <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/comm_uart_host.sv
// comm_uart_host: host end of the hex-over-UART mining link.
//   TX: one WORK_BITS work item -> 2*WORK_BITS/8 uppercase hex chars + '\n',
//       byte 0 (blockdata LSB) first, high nibble first within a byte.
//   RX: comm_hex_line_decoder turns hex lines into nonces / temperatures.
// Ports: clk, reset (sync, active-high); work_valid/work_ready/work_midstate/
//   work_blockdata (work input); tx_ready/tx_new_byte/tx_byte (to
//   uart_transmitter); rx_new_byte/rx_byte (from uart_receiver);
//   nonce_valid/nonce, temp_valid/temp, rx_error (decoded results).
// Optional build macro COMM_UART_HOST_WORK_QUEUE_EN: one-entry pending work
//   register (latest wins), work_ready always 1, frames run back-to-back.
module comm_uart_host
    import comm_uart_pkg::*;
#(
    parameter int WORK_BITS       = WORK_BITS_DEFAULT,
    parameter int TX_GUARD_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_blockdata,
    input  logic         tx_ready,
    output logic         tx_new_byte,
    output logic [7:0]   tx_byte,
    input  logic         rx_new_byte,
    input  logic [7:0]   rx_byte,
    output logic         nonce_valid,
    output logic [31:0]  nonce,
    output logic         temp_valid,
    output logic [15:0]  temp,
    output logic         rx_error
);

    localparam int             NBYTES    = WORK_BITS / 8;
    localparam int             IW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int             GW        = $clog2(TX_GUARD_CYCLES + 1);
    localparam logic [IW-1:0]  LAST_BYTE = IW'(NBYTES - 1);
    localparam logic [GW-1:0]  GUARD_LD  = GW'(TX_GUARD_CYCLES);

    tx_state_t            state, state_nxt;
    nib_phase_t           phase;
    logic [WORK_BITS-1:0] work_q;     // shifts right one byte per byte sent
    logic [WORK_BITS-1:0] work_in;
    logic [IW-1:0]        byte_idx;
    logic [GW-1:0]        guard;
    logic                 fire;       // send a character this cycle
    logic                 load_frame; // start a new frame at the next edge
    logic [7:0]           tx_char;

    assign work_in = WORK_BITS'({work_midstate, work_blockdata});

`ifdef COMM_UART_HOST_WORK_QUEUE_EN
    logic                 pend_vld;
    logic [WORK_BITS-1:0] pend_q;
    logic                 has_next;
    logic [WORK_BITS-1:0] load_val;

    // Work arriving in the very cycle a frame ends is newer than pending.
    assign has_next = work_valid || pend_vld;
    assign load_val = (state == TX_IDLE || work_valid) ? work_in : pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_q   <= '0;
        end else if (state != TX_IDLE && load_frame) begin
            pend_vld <= 1'b0;
        end else if (state != TX_IDLE && work_valid) begin
            pend_vld <= 1'b1;
            pend_q   <= work_in;
        end
    end
`else
    logic                 has_next;
    logic [WORK_BITS-1:0] load_val;
    assign has_next = 1'b0;
    assign load_val = work_in;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= TX_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE: if (work_valid) state_nxt = TX_SEND;
            TX_SEND: if (fire && phase == NIB_LO && byte_idx == LAST_BYTE)
                         state_nxt = TX_NL;
            TX_NL:   if (fire) state_nxt = has_next ? TX_SEND : TX_IDLE;
            default: state_nxt = TX_IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
`ifdef COMM_UART_HOST_WORK_QUEUE_EN
        work_ready = 1'b1;
`else
        work_ready = (state == TX_IDLE);
`endif
        // The guard hides tx_ready for a few cycles after a strobe, until
        // the transmitter's busy indication has had time to appear.
        fire       = (state != TX_IDLE) && tx_ready && (guard == '0);
        load_frame = (state == TX_IDLE && work_valid) ||
                     (state == TX_NL && fire && has_next);
        if (state == TX_NL)
            tx_char = CHAR_LF;
        else
            tx_char = hex_encode((phase == NIB_HI) ? work_q[7:4] : work_q[3:0]);
    end

    // TX datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_new_byte <= 1'b0;
            tx_byte     <= '0;
            guard       <= '0;
            byte_idx    <= '0;
            phase       <= NIB_HI;
            work_q      <= '0;
        end else begin
            tx_new_byte <= fire;
            if (fire) tx_byte <= tx_char;

            if (fire)              guard <= GUARD_LD;
            else if (guard != '0)  guard <= guard - GW'(1);

            if (load_frame) begin
                work_q   <= load_val;
                byte_idx <= '0;
                phase    <= NIB_HI;
            end else if (fire && state == TX_SEND) begin
                if (phase == NIB_HI) begin
                    phase <= NIB_LO;
                end else begin
                    phase    <= NIB_HI;
                    byte_idx <= byte_idx + IW'(1);
                    work_q   <= work_q >> 8;
                end
            end
        end
    end

    comm_hex_line_decoder u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_new_byte (rx_new_byte),
        .rx_byte     (rx_byte),
        .nonce_valid (nonce_valid),
        .nonce       (nonce),
        .temp_valid  (temp_valid),
        .temp        (temp),
        .rx_error    (rx_error)
    );

endmodule
